pipe_hazard_ctrl: RTL and testbench

Central pipeline controller for the 5-stage MIPS pipeline. It resolves control and load-use hazards that the forwarding unit cannot cover, and drives the PC-source select, pipeline-register stall and flush lines. It also sequences a debug halt: request/ack handshake, pipeline drain, then freeze. It keeps two saturating performance counters (stall cycles, redirect cycles).

---
 rtl/pipe_ctrl_pkg.sv | 17 +
 rtl/pipe_hazard_ctrl_sat_counter.sv | 22 ++
 rtl/pipe_hazard_ctrl.sv | 145 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and defaults for the pipeline hazard controller.
package pipe_ctrl_pkg;

   localparam int CNT_W_DEF        = 32;
   localparam int DRAIN_CYCLES_DEF = 3;

   localparam logic [1:0] PCSRC_SEQ = 2'b00;
   localparam logic [1:0] PCSRC_J   = 2'b01;
   localparam logic [1:0] PCSRC_BR  = 2'b10;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != {W{1'b1}})) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, redirect and debug-halt controller for the 5-stage pipeline.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int CNT_W        = CNT_W_DEF,
   parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       Rs_ID,
   input  logic [4:0]       Rt_ID,
   input  logic             RsUsed_ID,
   input  logic             RtUsed_ID,
   input  logic             MemToReg_Ex,
   input  logic             RegWr_Ex,
   input  logic [4:0]       Reg_Target_Ex,
   input  logic             Branch_Ex,
   input  logic             Jump_Ex,
   input  logic [31:0]      J_Addr_Ex,
   input  logic             BrTaken_Mem,
   input  logic [31:0]      B_Addr_Mem,
   input  logic             halt_req,
   input  logic             cnt_clr,
   output logic [1:0]       PC_Src,
   output logic [31:0]      PC_Target,
   output logic             stall_PC,
   output logic             stall_IF_ID,
   output logic             flush_IF_ID,
   output logic             flush_ID_EX,
   output logic             flush_Ex_Mem,
   output logic             halt_ack,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int DW =
      (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DW-1:0] DLOAD = DW'(DRAIN_CYCLES - 1);

   state_t        st_q, st_d;
   logic [DW-1:0] dcnt_q, dcnt_d;
   logic          lu, br, jp;
   logic          lu_inc, fl_inc;

   assign br = BrTaken_Mem;
   assign jp = Jump_Ex;
   assign lu = MemToReg_Ex && RegWr_Ex
            && (Reg_Target_Ex != 5'd0)
            && ((RsUsed_ID && (Reg_Target_Ex == Rs_ID))
             || (RtUsed_ID && (Reg_Target_Ex == Rt_ID)));

   always_comb begin
      st_d         = st_q;
      dcnt_d       = dcnt_q;
      PC_Src       = PCSRC_SEQ;
      PC_Target    = 32'd0;
      stall_PC     = 1'b0;
      stall_IF_ID  = 1'b0;
      flush_IF_ID  = 1'b0;
      flush_ID_EX  = 1'b0;
      flush_Ex_Mem = 1'b0;
      lu_inc       = 1'b0;
      fl_inc       = 1'b0;
      if (rst) begin
         unique case (st_q)
            ST_RUN: begin
               if (br) begin
                  PC_Src       = PCSRC_BR;
                  PC_Target    = B_Addr_Mem;
                  flush_IF_ID  = 1'b1;
                  flush_ID_EX  = 1'b1;
                  flush_Ex_Mem = 1'b1;
                  fl_inc       = 1'b1;
               end else if (jp) begin
                  PC_Src      = PCSRC_J;
                  PC_Target   = J_Addr_Ex;
                  flush_IF_ID = 1'b1;
                  flush_ID_EX = 1'b1;
                  fl_inc      = 1'b1;
               end else if (lu) begin
                  stall_PC    = 1'b1;
                  stall_IF_ID = 1'b1;
                  flush_ID_EX = 1'b1;
                  lu_inc      = 1'b1;
               end
               // never freeze with a redirect still in flight
               if (halt_req && !(br || jp || Branch_Ex)) begin
                  st_d   = ST_DRAIN;
                  dcnt_d = DLOAD;
               end
            end
            ST_DRAIN: begin
               stall_PC    = 1'b1;
               stall_IF_ID = 1'b1;
               flush_ID_EX = 1'b1;
               if (!halt_req) begin
                  st_d = ST_RUN;
               end else if (dcnt_q == '0) begin
                  st_d = ST_HALTED;
               end else begin
                  dcnt_d = dcnt_q - 1'b1;
               end
            end
            ST_HALTED: begin
               stall_PC    = 1'b1;
               stall_IF_ID = 1'b1;
               flush_ID_EX = 1'b1;
               if (!halt_req) begin
                  st_d = ST_RUN;
               end
            end
            default: st_d = ST_RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st_q     <= ST_RUN;
         dcnt_q   <= '0;
         halt_ack <= 1'b0;
      end else begin
         st_q     <= st_d;
         dcnt_q   <= dcnt_d;
         halt_ack <= (st_d == ST_HALTED);
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .inc (lu_inc),
      .clr (cnt_clr),
      .cnt (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk (clk),
      .rst (rst),
      .inc (fl_inc),
      .clr (cnt_clr),
      .cnt (flush_cnt)
   );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed checks for pipe_hazard_ctrl; a 3-bit-counter copy covers saturation.
module tb_pipe_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  Rs_ID, Rt_ID, Reg_Target_Ex;
   logic        RsUsed_ID, RtUsed_ID;
   logic        MemToReg_Ex, RegWr_Ex;
   logic        Branch_Ex, Jump_Ex, BrTaken_Mem;
   logic [31:0] J_Addr_Ex, B_Addr_Mem;
   logic        halt_req, cnt_clr;

   logic [1:0]  PC_Src, s_PC_Src;
   logic [31:0] PC_Target, s_PC_Target;
   logic        stall_PC, stall_IF_ID, flush_IF_ID;
   logic        flush_ID_EX, flush_Ex_Mem, halt_ack;
   logic        s_stall_PC, s_stall_IF_ID, s_flush_IF_ID;
   logic        s_flush_ID_EX, s_flush_Ex_Mem, s_halt_ack;
   logic [31:0] stall_cnt, flush_cnt;
   logic [2:0]  s_stall_cnt, s_flush_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl u_dut (
      .clk (clk), .rst (rst),
      .Rs_ID (Rs_ID), .Rt_ID (Rt_ID),
      .RsUsed_ID (RsUsed_ID), .RtUsed_ID (RtUsed_ID),
      .MemToReg_Ex (MemToReg_Ex), .RegWr_Ex (RegWr_Ex),
      .Reg_Target_Ex (Reg_Target_Ex),
      .Branch_Ex (Branch_Ex), .Jump_Ex (Jump_Ex),
      .J_Addr_Ex (J_Addr_Ex), .BrTaken_Mem (BrTaken_Mem),
      .B_Addr_Mem (B_Addr_Mem),
      .halt_req (halt_req), .cnt_clr (cnt_clr),
      .PC_Src (PC_Src), .PC_Target (PC_Target),
      .stall_PC (stall_PC), .stall_IF_ID (stall_IF_ID),
      .flush_IF_ID (flush_IF_ID), .flush_ID_EX (flush_ID_EX),
      .flush_Ex_Mem (flush_Ex_Mem), .halt_ack (halt_ack),
      .stall_cnt (stall_cnt), .flush_cnt (flush_cnt)
   );

   pipe_hazard_ctrl #(.CNT_W(3)) u_sat (
      .clk (clk), .rst (rst),
      .Rs_ID (Rs_ID), .Rt_ID (Rt_ID),
      .RsUsed_ID (RsUsed_ID), .RtUsed_ID (RtUsed_ID),
      .MemToReg_Ex (MemToReg_Ex), .RegWr_Ex (RegWr_Ex),
      .Reg_Target_Ex (Reg_Target_Ex),
      .Branch_Ex (Branch_Ex), .Jump_Ex (Jump_Ex),
      .J_Addr_Ex (J_Addr_Ex), .BrTaken_Mem (BrTaken_Mem),
      .B_Addr_Mem (B_Addr_Mem),
      .halt_req (halt_req), .cnt_clr (cnt_clr),
      .PC_Src (s_PC_Src), .PC_Target (s_PC_Target),
      .stall_PC (s_stall_PC), .stall_IF_ID (s_stall_IF_ID),
      .flush_IF_ID (s_flush_IF_ID), .flush_ID_EX (s_flush_ID_EX),
      .flush_Ex_Mem (s_flush_Ex_Mem), .halt_ack (s_halt_ack),
      .stall_cnt (s_stall_cnt), .flush_cnt (s_flush_cnt)
   );

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      Rs_ID = 0; Rt_ID = 0; Reg_Target_Ex = 0;
      RsUsed_ID = 0; RtUsed_ID = 0;
      MemToReg_Ex = 0; RegWr_Ex = 0;
      Branch_Ex = 0; Jump_Ex = 0; BrTaken_Mem = 0;
      J_Addr_Ex = 0; B_Addr_Mem = 0;
      cnt_clr = 0;
   endtask

   task automatic lw_dep(input logic [4:0] r);
      MemToReg_Ex = 1; RegWr_Ex = 1; Reg_Target_Ex = r;
      Rs_ID = r; RsUsed_ID = 1;
   endtask

   // advance one edge, then settle mid-cycle
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   initial begin
      rst = 0; halt_req = 0;
      idle();
      #3;
      lw_dep(5'd8); BrTaken_Mem = 1; halt_req = 1;
      #1;
      chk("rst_pcsrc", 32'(PC_Src), 0);
      chk("rst_stall", 32'(stall_PC), 0);
      chk("rst_fl_idid", 32'(flush_IF_ID), 0);
      chk("rst_ack", 32'(halt_ack), 0);
      chk("rst_scnt", stall_cnt, 0);
      idle(); halt_req = 0;
      #8 rst = 1;
      cyc();

      // load-use through Rs
      lw_dep(5'd8);
      #1;
      chk("lu_stall_pc", 32'(stall_PC), 1);
      chk("lu_stall_ifid", 32'(stall_IF_ID), 1);
      chk("lu_fl_idex", 32'(flush_ID_EX), 1);
      chk("lu_pcsrc", 32'(PC_Src), 0);
      cyc(); idle(); #1;
      chk("lu_one_cycle", 32'(stall_PC), 0);
      chk("lu_scnt", stall_cnt, 1);

      // $0 destination never stalls
      lw_dep(5'd0);
      #1;
      chk("lu_r0_stall", 32'(stall_PC), 0);
      cyc(); idle();
      // non-load writer never stalls
      lw_dep(5'd9); MemToReg_Ex = 0;
      #1;
      chk("lu_noload", 32'(stall_PC), 0);
      cyc(); idle();
      // load-use through Rt
      MemToReg_Ex = 1; RegWr_Ex = 1; Reg_Target_Ex = 9;
      Rt_ID = 9; RtUsed_ID = 1; Rs_ID = 3; RsUsed_ID = 1;
      #1;
      chk("lu_rt_stall", 32'(stall_PC), 1);
      cyc(); idle(); #1;
      chk("lu_rt_scnt", stall_cnt, 2);

      // taken branch beats a simultaneous load-use
      lw_dep(5'd8); BrTaken_Mem = 1; B_Addr_Mem = 32'h40;
      #1;
      chk("br_pcsrc", 32'(PC_Src), 2);
      chk("br_tgt", PC_Target, 32'h40);
      chk("br_fl_ifid", 32'(flush_IF_ID), 1);
      chk("br_fl_idex", 32'(flush_ID_EX), 1);
      chk("br_fl_exmem", 32'(flush_Ex_Mem), 1);
      chk("br_nostall", 32'(stall_PC), 0);
      cyc(); idle(); #1;
      chk("br_fcnt", flush_cnt, 1);
      chk("br_scnt", stall_cnt, 2);
      chk("seq_tgt0", PC_Target, 0);

      // jump
      Jump_Ex = 1; J_Addr_Ex = 32'h100;
      #1;
      chk("jp_pcsrc", 32'(PC_Src), 1);
      chk("jp_tgt", PC_Target, 32'h100);
      chk("jp_fl_ifid", 32'(flush_IF_ID), 1);
      chk("jp_fl_idex", 32'(flush_ID_EX), 1);
      chk("jp_fl_exmem", 32'(flush_Ex_Mem), 0);
      cyc(); idle(); #1;
      chk("jp_fcnt", flush_cnt, 2);

      // branch beats jump
      Jump_Ex = 1; J_Addr_Ex = 32'h100;
      BrTaken_Mem = 1; B_Addr_Mem = 32'h80;
      #1;
      chk("brjp_pcsrc", 32'(PC_Src), 2);
      chk("brjp_tgt", PC_Target, 32'h80);
      cyc(); idle(); #1;
      chk("brjp_fcnt", flush_cnt, 3);

      // halt from idle: 3 drain cycles, ack on the 4th
      halt_req = 1;
      #1;
      chk("h_run_nostall", 32'(stall_PC), 0);
      cyc(); #1;
      chk("h_d1_stall", 32'(stall_PC), 1);
      chk("h_d1_fl_idex", 32'(flush_ID_EX), 1);
      chk("h_d1_ack", 32'(halt_ack), 0);
      cyc(); #1;
      chk("h_d2_ack", 32'(halt_ack), 0);
      cyc(); #1;
      chk("h_d3_ack", 32'(halt_ack), 0);
      chk("h_d3_stall", 32'(stall_IF_ID), 1);
      cyc(); #1;
      chk("h_hlt_ack", 32'(halt_ack), 1);
      chk("h_hlt_stall", 32'(stall_PC), 1);
      lw_dep(5'd8);
      cyc(); idle(); #1;
      chk("h_lu_ignored", stall_cnt, 2);
      halt_req = 0;
      #1;
      chk("h_rel_ack_hold", 32'(halt_ack), 1);
      cyc(); #1;
      chk("h_rel_ack", 32'(halt_ack), 0);
      chk("h_rel_stall", 32'(stall_PC), 0);

      // halt deferred by a branch in Ex, then aborted in drain
      halt_req = 1; Branch_Ex = 1;
      cyc(); Branch_Ex = 0; #1;
      chk("hb_deferred", 32'(stall_PC), 0);
      cyc(); #1;
      chk("hb_drain", 32'(stall_PC), 1);
      halt_req = 0;
      cyc(); #1;
      chk("hb_abort", 32'(stall_PC), 0);
      chk("hb_abort_ack", 32'(halt_ack), 0);

      // async reset mid-drain
      halt_req = 1;
      cyc(); #1;
      chk("rd_drain", 32'(stall_PC), 1);
      rst = 0;
      #1;
      chk("rd_stall", 32'(stall_PC), 0);
      chk("rd_fl_idex", 32'(flush_ID_EX), 0);
      chk("rd_fcnt", flush_cnt, 0);
      chk("rd_scnt", stall_cnt, 0);
      halt_req = 0;
      #2 rst = 1;
      cyc(); #1;
      chk("rd_run", 32'(stall_PC), 0);
      chk("rd_ack", 32'(halt_ack), 0);

      // saturation: 9 load-use cycles
      lw_dep(5'd8);
      repeat (9) @(posedge clk);
      #2; idle(); #1;
      chk("sat_wide", stall_cnt, 9);
      chk("sat_narrow", 32'(s_stall_cnt), 7);
      lw_dep(5'd8); cnt_clr = 1;
      cyc(); idle(); #1;
      chk("clr_wide", stall_cnt, 0);
      chk("clr_narrow", 32'(s_stall_cnt), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
